// File: rtl/vector_writeback_collector.sv
// vector_writeback_collector
//   Sole driver of the vector register-file write port. ALU results are
//   registered straight through. Gather-load lanes arriving one per cycle
//   are collected into a per-lane buffer and issued as one masked write
//   once every requested lane has arrived and an ALU-free slot appears.
// Ports:
//   clk, reset_n              clock, synchronous active-low reset
//   alu_*_i                   single-cycle ALU vector result (valid/reg/value/mask)
//   gather_start_i/reg/mask   begin a gather (reg and mask captured on start)
//   gather_lane_valid/lane/data  one returning lane result per cycle
//   gather_busy_o             collecting or waiting for a write slot
//   gather_done_o             pulse when a gather retires
//   gather_overrun_o          pulse when a start is dropped (already busy)
//   write_en/reg/value/mask_o register-file write port (all zero when idle)

module vwc_lane (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clr_i,
  input  logic        ld_i,
  input  logic [31:0] d_i,
  output logic [31:0] q_o
);
  logic [31:0] data_d, data_q;

  always_comb begin
    data_d = data_q;
    if (clr_i)     data_d = '0;
    else if (ld_i) data_d = d_i;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) data_q <= '0;
    else          data_q <= data_d;
  end

  assign q_o = data_q;
endmodule

module vector_writeback_collector #(
  parameter int NUM_LANES = 16,
  parameter int REG_BITS  = 7,
  localparam int LANE_W   = $clog2(NUM_LANES)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   alu_valid_i,
  input  logic [REG_BITS-1:0]    alu_reg_i,
  input  logic [NUM_LANES*32-1:0] alu_value_i,
  input  logic [NUM_LANES-1:0]   alu_mask_i,
  input  logic                   gather_start_i,
  input  logic [REG_BITS-1:0]    gather_reg_i,
  input  logic [NUM_LANES-1:0]   gather_mask_i,
  input  logic                   gather_lane_valid_i,
  input  logic [LANE_W-1:0]      gather_lane_i,
  input  logic [31:0]            gather_data_i,
  output logic                   gather_busy_o,
  output logic                   gather_done_o,
  output logic                   gather_overrun_o,
  output logic                   write_en_o,
  output logic [REG_BITS-1:0]    write_reg_o,
  output logic [NUM_LANES*32-1:0] write_value_o,
  output logic [NUM_LANES-1:0]   write_mask_o
);
  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_PENDING} state_t;

  state_t                       state_d, state_q;
  logic [NUM_LANES-1:0]         rcv_d, rcv_q;
  logic [REG_BITS-1:0]          greg_d, greg_q;
  logic [NUM_LANES-1:0]         gmask_d, gmask_q;

  logic                         wen_d, wen_q;
  logic [REG_BITS-1:0]          wreg_d, wreg_q;
  logic [NUM_LANES-1:0][31:0]   wval_d, wval_q;
  logic [NUM_LANES-1:0]         wmask_d, wmask_q;
  logic                         done_d, done_q;
  logic                         ovr_d, ovr_q;

  logic                         buf_clr;
  logic [NUM_LANES-1:0]         lane_ld;
  logic [NUM_LANES-1:0][31:0]   lane_q;
  logic [NUM_LANES-1:0]         lane_oh;
  logic                         lane_hit;

  // Per-lane collection buffer
  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    vwc_lane u_lane (
      .clk    (clk),
      .reset_n(reset_n),
      .clr_i  (buf_clr),
      .ld_i   (lane_ld[g]),
      .d_i    (gather_data_i),
      .q_o    (lane_q[g])
    );
  end

  assign lane_oh  = {{(NUM_LANES-1){1'b0}}, 1'b1} << gather_lane_i;
  // Accept only a requested lane that has not arrived yet; duplicates keep first data.
  assign lane_hit = gather_lane_valid_i && |(lane_oh & gmask_q & ~rcv_q);

  always_comb begin
    state_d = state_q;
    rcv_d   = rcv_q;
    greg_d  = greg_q;
    gmask_d = gmask_q;
    buf_clr = 1'b0;
    lane_ld = '0;
    wen_d   = 1'b0;
    wreg_d  = '0;
    wval_d  = '0;
    wmask_d = '0;
    done_d  = 1'b0;
    ovr_d   = 1'b0;

    // ALU owns the write port whenever it is valid, in any state.
    if (alu_valid_i) begin
      wen_d   = 1'b1;
      wreg_d  = alu_reg_i;
      wval_d  = alu_value_i;
      wmask_d = alu_mask_i;
    end

    unique case (state_q)
      S_IDLE: begin
        if (gather_start_i) begin
          greg_d  = gather_reg_i;
          gmask_d = gather_mask_i;
          rcv_d   = '0;
          buf_clr = 1'b1;
          // An empty gather retires at once without touching the register file.
          if (gather_mask_i == '0) done_d  = 1'b1;
          else                     state_d = S_COLLECT;
        end
      end
      S_COLLECT: begin
        ovr_d = gather_start_i;
        if (lane_hit) begin
          lane_ld = lane_oh;
          rcv_d   = rcv_q | lane_oh;
          if ((rcv_q | lane_oh) == gmask_q) state_d = S_PENDING;
        end
      end
      S_PENDING: begin
        ovr_d = gather_start_i;
        if (!alu_valid_i) begin
          wen_d   = 1'b1;
          wreg_d  = greg_q;
          wmask_d = gmask_q;
          for (int i = 0; i < NUM_LANES; i++)
            wval_d[i] = gmask_q[i] ? lane_q[i] : 32'h0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      rcv_q   <= '0;
      greg_q  <= '0;
      gmask_q <= '0;
      wen_q   <= 1'b0;
      wreg_q  <= '0;
      wval_q  <= '0;
      wmask_q <= '0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rcv_q   <= rcv_d;
      greg_q  <= greg_d;
      gmask_q <= gmask_d;
      wen_q   <= wen_d;
      wreg_q  <= wreg_d;
      wval_q  <= wval_d;
      wmask_q <= wmask_d;
      done_q  <= done_d;
      ovr_q   <= ovr_d;
    end
  end

  assign gather_busy_o    = (state_q != S_IDLE);
  assign gather_done_o    = done_q;
  assign gather_overrun_o = ovr_q;
  assign write_en_o       = wen_q;
  assign write_reg_o      = wreg_q;
  assign write_value_o    = wval_q;
  assign write_mask_o     = wmask_q;
endmodule

// File: tb/tb_vector_writeback_collector.sv
module tb_vector_writeback_collector;
  logic         clk = 1'b0;
  logic         reset_n;
  logic         alu_valid_i;
  logic [6:0]   alu_reg_i;
  logic [511:0] alu_value_i;
  logic [15:0]  alu_mask_i;
  logic         gather_start_i;
  logic [6:0]   gather_reg_i;
  logic [15:0]  gather_mask_i;
  logic         gather_lane_valid_i;
  logic [3:0]   gather_lane_i;
  logic [31:0]  gather_data_i;
  logic         gather_busy_o, gather_done_o, gather_overrun_o, write_en_o;
  logic [6:0]   write_reg_o;
  logic [511:0] write_value_o;
  logic [15:0]  write_mask_o;

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 0;

  always #5 clk = ~clk;

  vector_writeback_collector dut (
    .clk(clk), .reset_n(reset_n),
    .alu_valid_i(alu_valid_i), .alu_reg_i(alu_reg_i),
    .alu_value_i(alu_value_i), .alu_mask_i(alu_mask_i),
    .gather_start_i(gather_start_i), .gather_reg_i(gather_reg_i),
    .gather_mask_i(gather_mask_i), .gather_lane_valid_i(gather_lane_valid_i),
    .gather_lane_i(gather_lane_i), .gather_data_i(gather_data_i),
    .gather_busy_o(gather_busy_o), .gather_done_o(gather_done_o),
    .gather_overrun_o(gather_overrun_o), .write_en_o(write_en_o),
    .write_reg_o(write_reg_o), .write_value_o(write_value_o),
    .write_mask_o(write_mask_o)
  );

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // mode: 0 = no gather, 1 = waiting for lanes, 2 = all lanes in, awaiting a free slot
  int          m_mode = 0;
  logic [6:0]  m_reg;
  logic [15:0] m_mask, m_got;
  logic [31:0] m_lane [16];
  logic        e_en, e_done, e_ovr;
  logic [6:0]  e_reg;
  logic [511:0] e_val;
  logic [15:0] e_mask;

  always @(posedge clk) begin
    e_en = 0; e_reg = 0; e_val = 0; e_mask = 0; e_done = 0; e_ovr = 0;
    if (!reset_n) begin
      m_mode = 0; m_reg = 0; m_mask = 0; m_got = 0;
      for (int n = 0; n < 16; n++) m_lane[n] = 0;
    end else begin
      if (alu_valid_i) begin
        e_en = 1; e_reg = alu_reg_i; e_val = alu_value_i; e_mask = alu_mask_i;
      end
      if (m_mode == 0) begin
        if (gather_start_i) begin
          m_reg = gather_reg_i; m_mask = gather_mask_i; m_got = 0;
          for (int n = 0; n < 16; n++) m_lane[n] = 0;
          if (gather_mask_i == 0) e_done = 1;
          else m_mode = 1;
        end
      end else begin
        if (gather_start_i) e_ovr = 1;
        if (m_mode == 1) begin
          if (gather_lane_valid_i && m_mask[gather_lane_i] && !m_got[gather_lane_i]) begin
            m_lane[gather_lane_i] = gather_data_i;
            m_got[gather_lane_i] = 1'b1;
            if (m_got == m_mask) m_mode = 2;
          end
        end else if (!alu_valid_i) begin
          e_en = 1; e_reg = m_reg; e_mask = m_mask; e_done = 1;
          for (int n = 0; n < 16; n++)
            if (m_mask[n]) e_val[32*n +: 32] = m_lane[n];
          m_mode = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy",     512'(gather_busy_o),    512'(m_mode != 0));
      chk("done",     512'(gather_done_o),    512'(e_done));
      chk("overrun",  512'(gather_overrun_o), 512'(e_ovr));
      chk("wen",      512'(write_en_o),       512'(e_en));
      chk("wreg",     512'(write_reg_o),      512'(e_reg));
      chk("wmask",    512'(write_mask_o),     512'(e_mask));
      chk("wvalue",   write_value_o,          e_val);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic quiet();
    alu_valid_i = 0; alu_reg_i = 0; alu_value_i = 0; alu_mask_i = 0;
    gather_start_i = 0; gather_reg_i = 0; gather_mask_i = 0;
    gather_lane_valid_i = 0; gather_lane_i = 0; gather_data_i = 0;
  endtask

  task automatic lane(input int l, input logic [31:0] d);
    gather_lane_valid_i = 1; gather_lane_i = 4'(l); gather_data_i = d; step();
    gather_lane_valid_i = 0;
  endtask

  task automatic start(input logic [6:0] r, input logic [15:0] m);
    gather_start_i = 1; gather_reg_i = r; gather_mask_i = m; step();
    gather_start_i = 0;
  endtask

  logic [511:0] vec;

  initial begin
    quiet();
    reset_n = 0;
    step(); step();
    chk_en = 1;
    chk("rst_wen",  512'(write_en_o), 512'(0));
    chk("rst_busy", 512'(gather_busy_o), 512'(0));
    reset_n = 1;
    step();

    // ALU passthrough
    vec = 0;
    for (int n = 0; n < 16; n++) vec[32*n +: 32] = 32'(n + 1);
    alu_valid_i = 1; alu_reg_i = 7'h25; alu_mask_i = 16'hFFFF; alu_value_i = vec;
    step();
    quiet();
    chk("alu_wen",   512'(write_en_o), 512'(1));
    chk("alu_reg",   512'(write_reg_o), 512'(7'h25));
    chk("alu_lane9", 512'(write_value_o[32*9 +: 32]), 512'(32'd10));
    step();
    chk("alu_idle_val", write_value_o, 512'(0));

    // Full gather, lanes 15..0
    start(7'h41, 16'hFFFF);
    for (int l = 15; l >= 0; l--) lane(l, 32'h1000 + 32'(l));
    chk("full_pending_wen",  512'(write_en_o), 512'(0));
    chk("full_pending_busy", 512'(gather_busy_o), 512'(1));
    step();
    chk("full_wen",   512'(write_en_o), 512'(1));
    chk("full_done",  512'(gather_done_o), 512'(1));
    chk("full_reg",   512'(write_reg_o), 512'(7'h41));
    chk("full_lane0", 512'(write_value_o[31:0]), 512'(32'h1000));
    chk("full_lane15",512'(write_value_o[511:480]), 512'(32'h100F));
    step();
    chk("full_after_busy", 512'(gather_busy_o), 512'(0));

    // Sparse gather, with a lane result on the start cycle and stray lanes
    gather_lane_valid_i = 1; gather_lane_i = 0; gather_data_i = 32'hDEAD;
    start(7'h12, 16'h0011);
    lane(1, 32'hAAAA);
    lane(4, 32'h4444);
    lane(4, 32'h9999);
    lane(0, 32'h0C0C);
    step();
    chk("sparse_mask",  512'(write_mask_o), 512'(16'h0011));
    chk("sparse_lane4", 512'(write_value_o[159:128]), 512'(32'h4444));
    chk("sparse_lane0", 512'(write_value_o[31:0]), 512'(32'h0C0C));
    chk("sparse_lane1", 512'(write_value_o[63:32]), 512'(0));
    step();

    // ALU contention
    start(7'h33, 16'h0003);
    lane(0, 32'h11);
    lane(1, 32'h22);
    alu_valid_i = 1; alu_reg_i = 7'h05; alu_mask_i = 16'h0001; alu_value_i = 512'h77;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("cont_alu_reg", 512'(write_reg_o), 512'(7'h05));
      chk("cont_busy",    512'(gather_busy_o), 512'(1));
    end
    quiet();
    step();
    chk("cont_g_reg",  512'(write_reg_o), 512'(7'h33));
    chk("cont_g_done", 512'(gather_done_o), 512'(1));
    step();

    // Zero-mask start
    start(7'h08, 16'h0000);
    chk("zero_done", 512'(gather_done_o), 512'(1));
    chk("zero_wen",  512'(write_en_o), 512'(0));
    step();

    // Start while busy
    start(7'h0A, 16'h0001);
    start(7'h7F, 16'hFFFF);
    chk("ovr_pulse", 512'(gather_overrun_o), 512'(1));
    lane(0, 32'hBEEF);
    step();
    chk("ovr_reg",  512'(write_reg_o), 512'(7'h0A));
    chk("ovr_mask", 512'(write_mask_o), 512'(16'h0001));
    step();

    // Reset mid-gather
    start(7'h44, 16'hFFFF);
    for (int l = 0; l < 5; l++) lane(l, 32'h500 + 32'(l));
    reset_n = 0; step(); reset_n = 1;
    chk("rst_mid_busy", 512'(gather_busy_o), 512'(0));
    for (int l = 5; l < 16; l++) begin
      lane(l, 32'h500 + 32'(l));
      chk("rst_mid_nowrite", 512'(write_en_o), 512'(0));
    end
    step();
    start(7'h01, 16'h0004);
    lane(2, 32'h22);
    step();
    chk("post_rst_lane2", 512'(write_value_o[95:64]), 512'(32'h22));
    chk("post_rst_reg",   512'(write_reg_o), 512'(7'h01));
    step();

    chk_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/vector_writeback_collector.md
# vector_writeback_collector

Sits directly upstream of the vector register file write port and is the only driver of it. Passes single-cycle ALU vector results through, and assembles gather-load results that return one 32-bit lane per cycle from the cache into a 512-bit buffer. Issues the assembled buffer as one masked register-file write. ALU writes always take priority, and a completed gather waits for a free write slot.

## Interface
- `NUM_LANES`, default 16: vector lanes, each 32 bits.
- `REG_BITS`, default 7: register index width (2-bit strand, 5-bit register).
- `clk`, input, 1: clock; all state updates on the rising edge.
- `reset_n`, input, 1: reset, synchronous, active-low.
- `alu_valid_i`, input, 1: ALU result is present this cycle.
- `alu_reg_i`, input, 7: ALU destination register.
- `alu_value_i`, input, 512: ALU result; lane n occupies bits [32n+31:32n].
- `alu_mask_i`, input, 16: ALU lane write mask.
- `gather_start_i`, input, 1: begin a gather.
- `gather_reg_i`, input, 7: gather destination register; sampled on start.
- `gather_mask_i`, input, 16: lanes the gather will return; sampled on start.
- `gather_lane_valid_i`, input, 1: one lane result is present.
- `gather_lane_i`, input, 4: index of the returning lane.
- `gather_data_i`, input, 32: lane data.
- `gather_busy_o`, output, 1: a gather is collecting or waiting to write.
- `gather_done_o`, output, 1: one-cycle pulse when a gather retires.
- `gather_overrun_o`, output, 1: one-cycle pulse when a start is dropped.
- `write_en_o`, output, 1: register-file write enable.
- `write_reg_o`, output, 7: register-file write index.
- `write_value_o`, output, 512: register-file write data.
- `write_mask_o`, output, 16: register-file lane mask.

## Operation
- **Reset.** `reset_n` low at an edge sets state to IDLE and clears the buffer, the received mask, the captured register and the captured mask.
  - All outputs read 0 after that edge.
  - Reset mid-gather discards all collected lanes; no write is issued.
- **States.**
  - IDLE: `gather_busy_o` = 0. On `gather_start_i`, capture the register and mask and clear the buffer and received mask.
    - Nonzero mask: go to COLLECT.
    - Zero mask: stay in IDLE, pulse `gather_done_o` on the next cycle, issue no write.
  - COLLECT: on `gather_lane_valid_i`, if the lane bit is set in the captured mask and clear in the received mask, store `gather_data_i` in that lane and set its received bit. Any other lane result is ignored.
    - When the received mask equals the captured mask after an update, go to PENDING.
  - PENDING: wait for a cycle with `alu_valid_i` = 0. In that cycle the gather write is registered and the state returns to IDLE.
- **ALU path.** `alu_valid_i` is registered straight to the write outputs in every state.
  - ALU writes are never stalled or dropped.
- **Gather write contents.** `write_reg_o` = captured register, `write_mask_o` = captured mask.
  - `write_value_o` carries the collected lanes; lanes outside the mask read 0.
- **Write outputs.** When no write is issued, `write_en_o` = 0 and `write_reg_o`, `write_value_o` and `write_mask_o` read 0.
- **Busy.** `gather_busy_o` = 1 in COLLECT and PENDING.
- **Illegal or ignored inputs.**
  - `gather_start_i` in COLLECT or PENDING is ignored, and `gather_overrun_o` pulses on the next cycle.
  - `gather_lane_valid_i` in IDLE or PENDING is ignored.
  - A lane result in the same cycle as an accepted start is ignored.

## Timing
- All outputs are registered.
- ALU latency is 1: `alu_valid_i` in cycle T gives `write_en_o` in cycle T+1.
- Gather timing:
  - Final lane accepted at edge E: state is PENDING from E.
  - If `alu_valid_i` = 0 in the cycle after E, the write and the `gather_done_o` pulse are visible after edge E+1.
  - Each cycle with `alu_valid_i` = 1 delays the write by one cycle.
- `gather_done_o` is high in the same cycle as the gather's `write_en_o`.
- A new start is accepted in the cycle after the gather write, since state is IDLE by then.
- Throughput is one lane per cycle; a full 16-lane gather takes 16 lane cycles plus at least 1 write cycle.

## Test plan
- **ALU passthrough.** `alu_valid_i`=1, `alu_reg_i`=0x25, mask 0xFFFF, value of incrementing words -> next cycle `write_en_o`=1 with identical reg, mask and value; in the following idle cycle all write outputs are 0.
- **Full gather, out of order.** Start reg 0x41, mask 0xFFFF; lanes arrive in order 15 down to 0 with data 0x1000+lane -> exactly one write the cycle after lane 0, mask 0xFFFF, lane n = 0x1000+n, `gather_done_o` pulses with it.
- **Sparse gather with stray lanes.** Mask 0x0011; lane 1 (not in mask), then lane 4, lane 4 again with different data, then lane 0 -> write mask 0x0011, lane 4 holds the first data, all other unmasked lanes 0.
- **ALU contention.** Gather completes while `alu_valid_i` is held high for 3 cycles -> three ALU writes first, then the gather write on the 4th cycle; `gather_busy_o` stays high until that write.
- **Start edge cases.** Start with mask 0 -> `gather_done_o` pulses one cycle later with no write. Start while busy -> `gather_overrun_o` pulses and the in-flight gather completes unchanged.
- **Reset mid-gather.** Reset after 5 of 16 lanes -> outputs 0; no gather write, even after the remaining lanes arrive; a new start is then accepted normally.
